sap_controller: RTL and testbench
=================================

// Module: sap_controller
// PURPOSE
//  Controller-sequencer for the SAP-1 datapath. A one-hot T-state ring counter steps
//  each instruction through fetch (T1-T3) and execute (T4-T6), and the block decodes
//  {T-state, opcode} into the control word that drives the program counter, MAR, RAM,
//  IR, A, ALU, B and output register. It owns HLT and is the only source of bus enables.
// PARAMETERS
//  NUM_TSTATES  6  ring length; the design is defined for 6 only
//  OPCODE_W     4  width of the opcode nibble from the IR
// PORTS
//  clock              in   1         system clock; ring and halt flag change on negedge
//  reset              in   1         asynchronous, active-high
//  opcode             in   OPCODE_W  IR upper nibble
//  pc_increment       out  1         Cp
//  pc_output_to_bus   out  1         Ep
//  mar_load           out  1         Lm
//  ram_output_to_bus  out  1         CE
//  ir_load            out  1         Li
//  ir_output_to_bus   out  1         Ei
//  a_load             out  1         La
//  a_output_to_bus    out  1         Ea
//  alu_subtract       out  1         Su
//  alu_output_to_bus  out  1         Eu
//  b_load             out  1         Lb
//  out_load           out  1         Lo
//  halted             out  1         HLT executed; sequencing frozen
//  tstate             out  NUM_TSTATES  one-hot ring value, bit0 = T1
// BEHAVIOUR
//  - Reset (async): tstate=6'b000001 (T1), halted=0; every control output is 0 while reset=1.
//  - Ring advances T1->T2->...->T6->T1 on each negedge clock; datapath loads on posedge,
//    so the control word is stable for a full half-cycle around every posedge.
//  - Opcodes: LDA=0000 ADD=0001 SUB=0010 OUT=1110 HLT=1111; all others are NOP.
//  - Control word (all signals not listed are 0):
//    T1: pc_output_to_bus, mar_load        T2: pc_increment        T3: ram_output_to_bus, ir_load
//    T4: LDA/ADD/SUB: ir_output_to_bus, mar_load; OUT: a_output_to_bus, out_load; else none
//    T5: LDA: ram_output_to_bus, a_load; ADD/SUB: ram_output_to_bus, b_load; else none
//    T6: ADD: alu_output_to_bus, a_load; SUB: alu_subtract, alu_output_to_bus, a_load; else none
//  - The control word is combinational from tstate and opcode. opcode is only decoded in
//    T4-T6, because IR is loaded at the posedge inside T3.
//  - Invariant: at most one *_output_to_bus is high in any state, including while halted.
//  - HLT: at the negedge that ends T4 with opcode=HLT, halted<=1 and the ring holds at T4.
//    While halted, all control outputs are 0. Only reset clears halted.
//  - A reset pulse mid-instruction abandons the instruction: next cycle after release is T1.
//  - opcode changes outside T4-T6 are ignored.
// CONFIGURATION
//  SAP_SKIP_NOP_EN defined: the ring returns to T1 after the last active state of the
//    instruction. LDA takes 5 clocks, ADD/SUB take 6, OUT takes 4, NOP opcodes take 3
//    (T3->T1). HLT is unchanged.
//  SAP_SKIP_NOP_EN undefined: every instruction takes exactly 6 clocks.
// STRUCTURE
//  - Package sap_pkg: opcode_t enum (LDA, ADD, SUB, OUT, HLT); tstate_t one-hot typedef
//    with T1..T6 constants; packed struct ctrl_word_t holding the 12 control bits.
//  - Sub-module sap_ring_counter: one-hot ring with negedge advance, async reset to T1,
//    hold input, and jump-to-T1 input. sap_controller holds the decode and the halt flag.
// TESTING
//  1 Reset released, opcode=0000 -> tstate 01,02,04,08,10,20,01 on successive negedges;
//    T1 Ep+Lm, T2 Cp, T3 CE+Li, T4 Ei+Lm, T5 CE+La.
//  2 opcode=0010 (SUB) -> T5 CE+Lb; T6 Su+Eu+La; alu_subtract=0 in every other state.
//  3 opcode=1111 at T4 -> halted=1 after that negedge; tstate stays 6'b001000 and all
//    control outputs are 0 for 20 clocks; reset -> halted=0 and tstate=T1.
//  4 reset pulsed during T5 of an ADD -> outputs 0 during reset; T1 decode on the first
//    clock after release.
//  5 opcode=1110 with SAP_SKIP_NOP_EN -> T4 Ea+Lo, then T1; opcode=0111 -> T3->T1.
//    Without the macro both sequences run all 6 states.
//  6 Random opcodes for 1000 cycles -> assertion that at most one bus enable is high.

Source files
------------

// File: rtl/sap_pkg.sv
// -----------------------------------------------------------------------------
// sap_pkg
// Shared types for the SAP-1 controller-sequencer.
//   opcode_t     : instruction opcodes; any value not listed here executes as NOP
//   tstate_t     : one-hot T-state ring value, bit0 = T1
//   T1..T6       : ring constants
//   ctrl_word_t  : the 12 control bits driven into the datapath
//   is_defined_op: true for opcodes that have their own execute sequence
// -----------------------------------------------------------------------------
package sap_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_t;

    typedef logic [5:0] tstate_t;

    localparam tstate_t T1 = 6'b000001;
    localparam tstate_t T2 = 6'b000010;
    localparam tstate_t T3 = 6'b000100;
    localparam tstate_t T4 = 6'b001000;
    localparam tstate_t T5 = 6'b010000;
    localparam tstate_t T6 = 6'b100000;

    typedef struct packed {
        logic pc_increment;
        logic pc_output_to_bus;
        logic mar_load;
        logic ram_output_to_bus;
        logic ir_load;
        logic ir_output_to_bus;
        logic a_load;
        logic a_output_to_bus;
        logic alu_subtract;
        logic alu_output_to_bus;
        logic b_load;
        logic out_load;
    } ctrl_word_t;

    function automatic logic is_defined_op(input opcode_t op);
        logic defined_s;
        case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT: defined_s = 1'b1;
            default:                                defined_s = 1'b0;
        endcase
        return defined_s;
    endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// -----------------------------------------------------------------------------
// sap_ring_counter
// One-hot T-state ring. Advances on the falling clock edge so that the
// decoded control word is settled around every rising edge, where the
// datapath loads.
//   clock  in   system clock (ring changes on negedge)
//   reset  in   asynchronous, active-high; forces T1
//   hold   in   keep the current state (halt)
//   jump   in   return to T1 instead of advancing (early instruction end)
//   tstate out  one-hot ring value, bit0 = T1
// -----------------------------------------------------------------------------
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    hold,
    input  logic    jump,
    output tstate_t tstate
);

    tstate_t tstate_r;
    logic    onehot_ok_s;

    // A corrupted ring (zero or multiple bits set) is steered back to T1.
    assign onehot_ok_s = (tstate_r != 6'b000000) &&
                         ((tstate_r & (tstate_r - 6'd1)) == 6'b000000);

    // Ring state: reset to T1, recover from corruption, hold, jump or rotate.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            tstate_r <= T1;
        end else if (!onehot_ok_s) begin
            tstate_r <= T1;
        end else if (hold) begin
            tstate_r <= tstate_r;
        end else if (jump) begin
            tstate_r <= T1;
        end else begin
            tstate_r <= {tstate_r[4:0], tstate_r[5]};
        end
    end

    assign tstate = tstate_r;

endmodule

// File: rtl/sap_controller.sv
// -----------------------------------------------------------------------------
// sap_controller
// SAP-1 controller-sequencer: steps each instruction through fetch (T1-T3)
// and execute (T4-T6) and decodes {T-state, opcode} into the datapath
// control word. Owns the HLT flag.
// Configuration macro: SAP_SKIP_NOP_EN -- when defined, the ring returns to T1
// right after the last active state of each instruction (LDA 5, ADD/SUB 6,
// OUT 4, NOP 3 clocks); otherwise every instruction takes 6 clocks.
//   clock             in   system clock; ring and halt flag change on negedge
//   reset             in   asynchronous, active-high
//   opcode            in   IR upper nibble
//   pc_increment      out  Cp     pc_output_to_bus  out  Ep
//   mar_load          out  Lm     ram_output_to_bus out  CE
//   ir_load           out  Li     ir_output_to_bus  out  Ei
//   a_load            out  La     a_output_to_bus   out  Ea
//   alu_subtract      out  Su     alu_output_to_bus out  Eu
//   b_load            out  Lb     out_load          out  Lo
//   halted            out  HLT executed; sequencing frozen
//   tstate            out  one-hot ring value, bit0 = T1
// -----------------------------------------------------------------------------
module sap_controller
    import sap_pkg::*;
#(
    parameter int NUM_TSTATES = 6,
    parameter int OPCODE_W    = 4
)
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [OPCODE_W-1:0]    opcode,
    output logic                   pc_increment,
    output logic                   pc_output_to_bus,
    output logic                   mar_load,
    output logic                   ram_output_to_bus,
    output logic                   ir_load,
    output logic                   ir_output_to_bus,
    output logic                   a_load,
    output logic                   a_output_to_bus,
    output logic                   alu_subtract,
    output logic                   alu_output_to_bus,
    output logic                   b_load,
    output logic                   out_load,
    output logic                   halted,
    output logic [NUM_TSTATES-1:0] tstate
);

    opcode_t    op_s;
    tstate_t    tstate_s;
    ctrl_word_t ctrl_s;
    logic       halted_r;
    logic       halt_now_s;
    logic       hold_s;
    logic       jump_s;

    assign op_s       = opcode_t'(opcode);
    assign halt_now_s = (tstate_s == T4) && (op_s == OP_HLT) && !halted_r;
    assign hold_s     = halted_r || halt_now_s;

    sap_ring_counter u_ring (
        .clock  (clock),
        .reset  (reset),
        .hold   (hold_s),
        .jump   (jump_s),
        .tstate (tstate_s)
    );

`ifdef SAP_SKIP_NOP_EN
    // Early return to T1 once the instruction has no further active states.
    always_comb begin
        jump_s = 1'b0;
        case (tstate_s)
            T3:      jump_s = !is_defined_op(op_s);
            T4:      jump_s = (op_s == OP_OUT);
            T5:      jump_s = (op_s == OP_LDA);
            default: jump_s = 1'b0;
        endcase
    end
`else
    assign jump_s = 1'b0;
`endif

    // Halt flag: set at the negedge that ends T4 of HLT, cleared only by reset.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            halted_r <= 1'b0;
        end else if (halt_now_s) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end

    // Control word decode; forced quiet during reset and after HLT so no
    // bus driver is ever enabled in those conditions.
    always_comb begin
        ctrl_s = '0;
        if (reset || halted_r) begin
            ctrl_s = '0;
        end else begin
            case (tstate_s)
                T1: begin
                    ctrl_s.pc_output_to_bus = 1'b1;
                    ctrl_s.mar_load         = 1'b1;
                end
                T2: ctrl_s.pc_increment = 1'b1;
                T3: begin
                    ctrl_s.ram_output_to_bus = 1'b1;
                    ctrl_s.ir_load           = 1'b1;
                end
                T4: begin
                    case (op_s)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ctrl_s.ir_output_to_bus = 1'b1;
                            ctrl_s.mar_load         = 1'b1;
                        end
                        OP_OUT: begin
                            ctrl_s.a_output_to_bus = 1'b1;
                            ctrl_s.out_load        = 1'b1;
                        end
                        default: ctrl_s = '0;
                    endcase
                end
                T5: begin
                    case (op_s)
                        OP_LDA: begin
                            ctrl_s.ram_output_to_bus = 1'b1;
                            ctrl_s.a_load            = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl_s.ram_output_to_bus = 1'b1;
                            ctrl_s.b_load            = 1'b1;
                        end
                        default: ctrl_s = '0;
                    endcase
                end
                T6: begin
                    case (op_s)
                        OP_ADD: begin
                            ctrl_s.alu_output_to_bus = 1'b1;
                            ctrl_s.a_load            = 1'b1;
                        end
                        OP_SUB: begin
                            ctrl_s.alu_subtract      = 1'b1;
                            ctrl_s.alu_output_to_bus = 1'b1;
                            ctrl_s.a_load            = 1'b1;
                        end
                        default: ctrl_s = '0;
                    endcase
                end
                default: ctrl_s = '0;
            endcase
        end
    end

    assign pc_increment      = ctrl_s.pc_increment;
    assign pc_output_to_bus  = ctrl_s.pc_output_to_bus;
    assign mar_load          = ctrl_s.mar_load;
    assign ram_output_to_bus = ctrl_s.ram_output_to_bus;
    assign ir_load           = ctrl_s.ir_load;
    assign ir_output_to_bus  = ctrl_s.ir_output_to_bus;
    assign a_load            = ctrl_s.a_load;
    assign a_output_to_bus   = ctrl_s.a_output_to_bus;
    assign alu_subtract      = ctrl_s.alu_subtract;
    assign alu_output_to_bus = ctrl_s.alu_output_to_bus;
    assign b_load            = ctrl_s.b_load;
    assign out_load          = ctrl_s.out_load;
    assign halted            = halted_r;
    assign tstate            = tstate_s;

endmodule

// File: tb/tb_sap_controller.sv
// -----------------------------------------------------------------------------
// tb_sap_controller
// Self-checking bench for sap_controller. A step-number model (1..6 plus a
// halt flag) predicts the ring position and the control word from the
// instruction table; outputs are sampled 1 time unit after each posedge.
// -----------------------------------------------------------------------------
module tb_sap_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic       pc_increment, pc_output_to_bus, mar_load, ram_output_to_bus;
    logic       ir_load, ir_output_to_bus, a_load, a_output_to_bus;
    logic       alu_subtract, alu_output_to_bus, b_load, out_load, halted;
    logic [5:0] tstate;

    int errors = 0;
    int checks = 0;
    int step_m;
    bit halted_m;

    // Control bit masks, order {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
    localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100;
    localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
    localparam logic [11:0] SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;

    sap_controller #(.NUM_TSTATES(6), .OPCODE_W(4)) dut (
        .clock(clock), .reset(reset), .opcode(opcode),
        .pc_increment(pc_increment), .pc_output_to_bus(pc_output_to_bus),
        .mar_load(mar_load), .ram_output_to_bus(ram_output_to_bus),
        .ir_load(ir_load), .ir_output_to_bus(ir_output_to_bus),
        .a_load(a_load), .a_output_to_bus(a_output_to_bus),
        .alu_subtract(alu_subtract), .alu_output_to_bus(alu_output_to_bus),
        .b_load(b_load), .out_load(out_load),
        .halted(halted), .tstate(tstate)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (step=%0d op=%0h t=%0t)",
                     tag, got, exp, step_m, opcode, $time);
        end
    endtask

    // Number of clocks an instruction occupies before the ring returns to T1.
    function automatic int last_step(input logic [3:0] op);
`ifdef SAP_SKIP_NOP_EN
        case (op)
            4'h0:       return 5;
            4'h1, 4'h2: return 6;
            4'hE:       return 4;
            4'hF:       return 6;
            default:    return 3;
        endcase
`else
        return 6;
`endif
    endfunction

    function automatic logic [11:0] exp_ctrl(input int step, input logic [3:0] op,
                                             input bit hlt, input logic rst);
        logic [11:0] w = 12'h000;
        if (rst || hlt) return 12'h000;
        case (step)
            1: w = EP | LM;
            2: w = CP;
            3: w = CE | LI;
            4: if (op <= 4'h2) w = EI | LM; else if (op == 4'hE) w = EA | LO;
            5: if (op == 4'h0) w = CE | LA; else if (op == 4'h1 || op == 4'h2) w = CE | LB;
            6: if (op == 4'h1) w = EU | LA; else if (op == 4'h2) w = SU | EU | LA;
            default: w = 12'h000;
        endcase
        return w;
    endfunction

    task automatic compare_all();
        logic [11:0] obs;
        int          bus_cnt;
        obs = {pc_increment, pc_output_to_bus, mar_load, ram_output_to_bus, ir_load,
               ir_output_to_bus, a_load, a_output_to_bus, alu_subtract,
               alu_output_to_bus, b_load, out_load};
        bus_cnt = int'(pc_output_to_bus) + int'(ram_output_to_bus) + int'(ir_output_to_bus)
                + int'(a_output_to_bus) + int'(alu_output_to_bus);
        check_eq("tstate", 32'(tstate), 32'(1) << (step_m - 1));
        check_eq("halted", 32'(halted), 32'(halted_m));
        check_eq("ctrl", 32'(obs), 32'(exp_ctrl(step_m, opcode, halted_m, reset)));
        check_eq("bus1", 32'(bus_cnt <= 1), 32'd1);
    endtask

    task automatic model_step();
        if (reset) begin
            step_m   = 1;
            halted_m = 1'b0;
        end else if (halted_m) begin
            step_m = step_m;
        end else if (step_m == 4 && opcode == 4'hF) begin
            halted_m = 1'b1;
        end else begin
            step_m = (step_m >= last_step(opcode)) ? 1 : step_m + 1;
        end
    endtask

    // One clock: check around the posedge, then advance the model at the negedge.
    task automatic cycle();
        @(posedge clock);
        #1;
        compare_all();
        @(negedge clock);
        model_step();
        #1;
    endtask

    task automatic run_instr(input logic [3:0] op);
        opcode = op;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (step_m == 1 || halted_m) break;
        end
    endtask

    // Reset pulse asserted in the high phase, released just after the negedge.
    task automatic pulse_reset();
        @(posedge clock);
        #1;
        compare_all();
        #1;
        reset    = 1'b1;
        step_m   = 1;
        halted_m = 1'b0;
        #1;
        compare_all();
        @(negedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        opcode   = 4'h0;
        step_m   = 1;
        halted_m = 1'b0;
        #1;
        compare_all();
        cycle();
        cycle();
        reset = 1'b0;

        run_instr(4'h0);
        run_instr(4'h2);
        run_instr(4'h1);
        run_instr(4'hE);
        run_instr(4'h7);
        run_instr(4'h0);

        run_instr(4'hF);
        repeat (20) cycle();
        check_eq("hlt_hold", 32'(halted), 32'd1);
        pulse_reset();
        check_eq("hlt_clear", 32'(halted), 32'd0);

        opcode = 4'h1;
        repeat (4) cycle();
        pulse_reset();
        run_instr(4'h0);

        for (int n = 0; n < 1000; n++) begin
            if (halted_m) begin
                pulse_reset();
            end else if (step_m == 1) begin
                opcode = 4'($urandom_range(0, 15));
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
